// File: rtl/ser_frame_collector.sv
// ser_frame_collector
//
// Purpose: downstream stage of the serial flag-detecting receiver. Packs the
// qualified payload bit stream MSB-first into bytes, buffers them in a small
// first-word-fall-through FIFO with a valid/ready output, and reports frame
// completion, abort and FIFO overflow.
//
// Optional feature macro: FRAME_PARITY_EN (adds output frameParity).
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   serIn         payload bit from upstream receiver
//   serValid      serIn qualifies this cycle (high for the whole frame body)
//   serAbort      upstream abort indication (wins over serValid and outReady)
//   outData       FIFO head byte, 8'h00 when the FIFO is empty
//   outValid      FIFO non-empty
//   outReady      consumer accepts head when outValid & outReady
//   frameDone     one-cycle pulse, frame ended normally
//   frameAbort    one-cycle pulse, frame aborted while receiving
//   frameBytes    completed bytes of the last/current frame (saturating)
//   overflow      sticky: a byte was dropped because the FIFO was full
//   frameParity   (FRAME_PARITY_EN only) XOR of all payload bits of the frame
module ser_frame_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serIn,
  input  logic             serValid,
  input  logic             serAbort,
  output logic [7:0]       outData,
  output logic             outValid,
  input  logic             outReady,
  output logic             frameDone,
  output logic             frameAbort,
  output logic [CNT_W-1:0] frameBytes,
`ifdef FRAME_PARITY_EN
  output logic             frameParity,
`endif
  output logic             overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam logic [FCNT_W-1:0] FULL     = FCNT_W'(DEPTH);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t state, state_n;

  // FSM strobes
  logic take_bit;     // serIn is a payload bit this cycle
  logic frame_start;  // first payload bit of a new frame
  logic done_set;
  logic abort_set;
  logic flush;

  // Deserializer stage
  logic [6:0] shreg_p0;
  logic [2:0] bit_cnt_p0;
  logic [2:0] eff_cnt_p0;
  logic [7:0] byte_p0;
  logic       vld_p0;

  // FIFO stage
  logic [7:0]        mem_p1 [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [PTR_W-1:0]  rd_ptr_p1;
  logic [FCNT_W-1:0] count_p1;
  logic              pop;
  logic              push_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = CNT_W'(1);
    if (v == {CNT_W{1'b1}}) return v;
    return v + one;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    take_bit    = 1'b0;
    frame_start = 1'b0;
    done_set    = 1'b0;
    abort_set   = 1'b0;
    flush       = 1'b0;
    if (serAbort) begin
      flush     = 1'b1;
      abort_set = (state == RECV);
      state_n   = DRAIN;
    end else begin
      case (state)
        IDLE: begin
          if (serValid) begin
            frame_start = 1'b1;
            take_bit    = 1'b1;
            state_n     = RECV;
          end
        end
        RECV: begin
          if (serValid) begin
            take_bit = 1'b1;
          end else begin
            done_set = 1'b1;
            state_n  = IDLE;
          end
        end
        DRAIN: begin
          if (!serValid) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // ---- stage p0: bit assembly ----
  // A new frame always starts counting from bit zero, whatever was left over.
  assign eff_cnt_p0 = frame_start ? 3'd0 : bit_cnt_p0;
  assign vld_p0     = take_bit && (eff_cnt_p0 == 3'd7);
  assign byte_p0    = {shreg_p0, serIn};

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_p0 <= 3'd0;
    end else if (flush || done_set) begin
      bit_cnt_p0 <= 3'd0;
    end else if (take_bit) begin
      bit_cnt_p0 <= eff_cnt_p0 + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush)         shreg_p0 <= 7'd0;
    else if (take_bit) shreg_p0 <= {shreg_p0[5:0], serIn};
  end

  // ---- stage p1: FWFT FIFO ----
  // A pop frees a slot in the same edge, so a push into a full FIFO that
  // coincides with a pop is accepted.
  assign pop     = (count_p1 != '0) && outReady && !serAbort;
  assign push_ok = vld_p0 && ((count_p1 != FULL) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_p1[wr_ptr_p1] <= byte_p0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      if (push_ok) wr_ptr_p1 <= wr_ptr_p1 + PTR_ONE;
      if (pop)     rd_ptr_p1 <= rd_ptr_p1 + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count_p1 <= count_p1 + FCNT_ONE;
        2'b01:   count_p1 <= count_p1 - FCNT_ONE;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  assign outValid = (count_p1 != '0);
  assign outData  = outValid ? mem_p1[rd_ptr_p1] : 8'h00;

  // ---- frame status ----
  always_ff @(posedge clk) begin
    if (rst) begin
      frameDone  <= 1'b0;
      frameAbort <= 1'b0;
      frameBytes <= '0;
      overflow   <= 1'b0;
    end else begin
      frameDone  <= done_set;
      frameAbort <= abort_set;
      // Dropped bytes still count as completed bytes of the frame.
      if (frame_start)  frameBytes <= '0;
      else if (vld_p0)  frameBytes <= sat_inc(frameBytes);
      if (frame_start)                overflow <= 1'b0;
      else if (vld_p0 && !push_ok)    overflow <= 1'b1;
    end
  end

`ifdef FRAME_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || flush)     frameParity <= 1'b0;
    else if (frame_start) frameParity <= serIn;
    else if (take_bit)    frameParity <= frameParity ^ serIn;
  end
`endif

endmodule

// File: tb/tb_ser_frame_collector.sv
// Directed bench for ser_frame_collector (DEPTH=4, CNT_W=8).
module tb_ser_frame_collector;

  logic       clk;
  logic       rst;
  logic       serIn;
  logic       serValid;
  logic       serAbort;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       frameDone;
  logic       frameAbort;
  logic [7:0] frameBytes;
  logic       overflow;
`ifdef FRAME_PARITY_EN
  logic       frameParity;
`endif

  int errors = 0;
  int checks = 0;

  ser_frame_collector #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .serIn      (serIn),
    .serValid   (serValid),
    .serAbort   (serAbort),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .frameDone  (frameDone),
    .frameAbort (frameAbort),
    .frameBytes (frameBytes),
`ifdef FRAME_PARITY_EN
    .frameParity(frameParity),
`endif
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input on the falling edge, return 1 time unit after
  // the following rising edge so outputs reflect that edge.
  task automatic cyc(input logic b, input logic v, input logic a);
    @(negedge clk);
    serIn = b; serValid = v; serAbort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) cyc(d[i], 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (outData !== 8'h00) begin errors++; $display("FAIL reset_outData got %h exp 00", outData); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b exp 0", outValid); end
    checks++; if (frameDone !== 1'b0 || frameAbort !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", frameDone, frameAbort); end
    checks++; if (frameBytes !== 8'd0) begin errors++; $display("FAIL reset_frameBytes got %0d exp 0", frameBytes); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_basic;
    logic [15:0] d;
    d = 16'hA53C;
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(d[15-i], 1'b1, 1'b0);
      if (i == 7) begin
        checks++; if (outValid !== 1'b1 || outData !== 8'hA5) begin errors++; $display("FAIL basic_byte0 got v=%b %h exp v=1 a5", outValid, outData); end
      end
      if (i == 8) begin
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL basic_pop0 got v=%b exp 0", outValid); end
      end
      if (i == 15) begin
        checks++; if (outValid !== 1'b1 || outData !== 8'h3C) begin errors++; $display("FAIL basic_byte1 got v=%b %h exp v=1 3c", outValid, outData); end
      end
    end
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b exp 0", frameDone); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameDone !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", frameDone); end
    checks++; if (frameBytes !== 8'd2) begin errors++; $display("FAIL basic_bytes got %0d exp 2", frameBytes); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", outValid); end
`ifdef FRAME_PARITY_EN
    checks++; if (frameParity !== 1'b0) begin errors++; $display("FAIL basic_parity got %b exp 0", frameParity); end
`endif
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", frameDone); end
  endtask

  task automatic test_partial;
    outReady = 1'b0;
    send_byte(8'hFF);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameDone !== 1'b1) begin errors++; $display("FAIL partial_done got %b exp 1", frameDone); end
    checks++; if (frameBytes !== 8'd1) begin errors++; $display("FAIL partial_bytes got %0d exp 1", frameBytes); end
    checks++; if (outValid !== 1'b1 || outData !== 8'hFF) begin errors++; $display("FAIL partial_head got v=%b %h exp v=1 ff", outValid, outData); end
    outReady = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (outValid !== 1'b0 || outData !== 8'h00) begin errors++; $display("FAIL partial_only_one got v=%b %h exp v=0 00", outValid, outData); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp [5];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    outReady = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(exp[k]);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got %b exp 0", overflow); end
    send_byte(exp[4]);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameBytes !== 8'd5) begin errors++; $display("FAIL ovf_bytes got %0d exp 5", frameBytes); end
    outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (outValid !== 1'b1 || outData !== exp[k]) begin errors++; $display("FAIL ovf_pop%0d got v=%b %h exp v=1 %h", k, outValid, outData, exp[k]); end
      cyc(1'b0, 1'b0, 1'b0);
    end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", outValid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_abort;
    outReady = 1'b0;
    send_byte(8'hF0);
    send_byte(8'h0F);
    for (int i = 0; i < 4; i++) cyc(i[0], 1'b1, 1'b0);
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL abort_pre_fill got %b exp 1", outValid); end
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (frameAbort !== 1'b1) begin errors++; $display("FAIL abort_pulse got %b exp 1", frameAbort); end
    checks++; if (outValid !== 1'b0 || outData !== 8'h00) begin errors++; $display("FAIL abort_flush got v=%b %h exp v=0 00", outValid, outData); end
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", frameDone); end
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (frameAbort !== 1'b0 || frameDone !== 1'b0) begin errors++; $display("FAIL abort_drain got a=%b d=%b exp 0 0", frameAbort, frameDone); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameDone !== 1'b0 || outValid !== 1'b0) begin errors++; $display("FAIL abort_exit got d=%b v=%b exp 0 0", frameDone, outValid); end
    outReady = 1'b1;
    send_byte(8'h81);
    checks++; if (outValid !== 1'b1 || outData !== 8'h81) begin errors++; $display("FAIL abort_next_byte got v=%b %h exp v=1 81", outValid, outData); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameDone !== 1'b1 || frameBytes !== 8'd1) begin errors++; $display("FAIL abort_next_done got d=%b n=%0d exp 1 1", frameDone, frameBytes); end
  endtask

  task automatic test_full_pushpop;
    logic [7:0] b;
    outReady = 1'b0;
    for (int k = 1; k <= 4; k++) send_byte(8'(k));
    b = 8'h05;
    for (int i = 7; i >= 1; i--) cyc(b[i], 1'b1, 1'b0);
    outReady = 1'b1;
    cyc(b[0], 1'b1, 1'b0);
    outReady = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pp_ovf got %b exp 0", overflow); end
    checks++; if (outData !== 8'h02) begin errors++; $display("FAIL full_pp_head got %h exp 02", outData); end
    cyc(1'b0, 1'b0, 1'b0);
    outReady = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      checks++; if (outValid !== 1'b1 || outData !== 8'(k)) begin errors++; $display("FAIL full_pp_pop%0d got v=%b %h exp v=1 %h", k, outValid, outData, 8'(k)); end
      cyc(1'b0, 1'b0, 1'b0);
    end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL full_pp_count got %b exp 0", outValid); end
  endtask

  task automatic test_reset_mid;
    outReady = 1'b0;
    send_byte(8'h5A);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    checks++; if (outValid !== 1'b1 || frameBytes !== 8'd0) begin errors++; $display("FAIL rstmid_pre got v=%b n=%0d exp 1 0", outValid, frameBytes); end
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    checks++; if (outValid !== 1'b0 || outData !== 8'h00) begin errors++; $display("FAIL rstmid_fifo got v=%b %h exp v=0 00", outValid, outData); end
    checks++; if (frameDone !== 1'b0 || frameAbort !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_flags got d=%b a=%b o=%b exp 0 0 0", frameDone, frameAbort, overflow); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameDone !== 1'b0 || frameAbort !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse got d=%b a=%b exp 0 0", frameDone, frameAbort); end
  endtask

`ifdef FRAME_PARITY_EN
  task automatic test_parity;
    outReady = 1'b1;
    send_byte(8'h07);
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameDone !== 1'b1 || frameParity !== 1'b1) begin errors++; $display("FAIL parity_07 got d=%b p=%b exp 1 1", frameDone, frameParity); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (frameParity !== 1'b1) begin errors++; $display("FAIL parity_hold got %b exp 1", frameParity); end
  endtask
`endif

  initial begin
    rst = 1'b0; serIn = 1'b0; serValid = 1'b0; serAbort = 1'b0; outReady = 1'b0;
    test_reset;
    test_basic;
    test_partial;
    test_overflow;
    test_abort;
    test_full_pushpop;
    test_reset_mid;
`ifdef FRAME_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
